// File: rtl/stream_avg_div.sv
// Streaming signed accumulate-then-divide unit.
// Accepts up to MAXCNT signed samples over valid/ready, sums them at full
// precision, divides the sum by a latched signed divisor with a bit-serial
// restoring divider and returns a saturated, truncated-toward-zero quotient.
module stream_avg_div #(
  parameter int DATAWIDTH = 16,
  parameter int MAXCNT    = 8,
  parameter int CNTW      = $clog2(MAXCNT + 1),
  parameter int ACCW      = DATAWIDTH + CNTW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNTW-1:0]             num_samples,
  input  logic signed [DATAWIDTH-1:0] num,
  input  logic                        in_valid,
  input  logic signed [DATAWIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATAWIDTH-1:0] avg,
  output logic                        sat,
  output logic                        div_zero
);

  localparam int ITW = $clog2(ACCW + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                      state, state_nxt;
  logic [CNTW-1:0]             cnt_left;
  logic signed [DATAWIDTH-1:0] num_q;
  logic signed [ACCW-1:0]      acc;
  logic [ACCW-1:0]             quo;
  logic [ACCW:0]               rem;
  logic [ITW-1:0]              iter;
  logic signed [DATAWIDTH-1:0] avg_q;
  logic                        sat_q;
  logic                        dz_q;

  logic [ACCW-1:0]             dvd;
  logic [ACCW:0]               dvs;
  logic [ACCW:0]               rem_sh;
  logic [ACCW:0]               rem_nx;
  logic [ACCW-1:0]             quo_nx;
  logic                        q_neg;
  logic signed [ACCW:0]        q_signed;
  logic [DATAWIDTH:0]          q_sat;
  logic                        xfer;

  // Requested count limited to the supported maximum.
  function automatic logic [CNTW-1:0] clamp_cnt(input logic [CNTW-1:0] n);
    if (n > CNTW'(MAXCNT)) return CNTW'(MAXCNT);
    return n;
  endfunction

  // Magnitude of the accumulator; the most negative sum maps to 2^(ACCW-1).
  function automatic logic [ACCW-1:0] abs_acc(input logic signed [ACCW-1:0] a);
    if (a[ACCW-1]) return $unsigned(-a);
    return $unsigned(a);
  endfunction

  // Magnitude of the divisor, zero-extended to the remainder width.
  function automatic logic [ACCW:0] abs_num(input logic signed [DATAWIDTH-1:0] d);
    logic [DATAWIDTH-1:0] m;
    m = d[DATAWIDTH-1] ? $unsigned(-d) : $unsigned(d);
    return {{(ACCW + 1 - DATAWIDTH){1'b0}}, m};
  endfunction

  // Clamp a wide signed quotient to DATAWIDTH; MSB of the result is the sat flag.
  function automatic logic [DATAWIDTH:0] sat_fn(input logic signed [ACCW:0] v);
    logic signed [ACCW:0] maxv;
    logic signed [ACCW:0] minv;
    maxv = {{(ACCW - DATAWIDTH + 2){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
    minv = {{(ACCW - DATAWIDTH + 2){1'b1}}, {(DATAWIDTH - 1){1'b0}}};
    if (v > maxv) return {1'b1, maxv[DATAWIDTH-1:0]};
    if (v < minv) return {1'b1, minv[DATAWIDTH-1:0]};
    return {1'b0, v[DATAWIDTH-1:0]};
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign avg       = avg_q;
  assign sat       = sat_q;
  assign div_zero  = dz_q;
  assign xfer      = in_valid & in_ready;

  // One restoring-division step plus sign/saturation of the finished quotient.
  always_comb begin
    dvd    = (iter == '0) ? abs_acc(acc) : quo;
    dvs    = abs_num(num_q);
    rem_sh = {rem[ACCW-1:0], dvd[ACCW-1]};
    rem_nx = rem_sh;
    quo_nx = {dvd[ACCW-2:0], 1'b0};
    if (rem_sh >= dvs) begin
      rem_nx = rem_sh - dvs;
      quo_nx = {dvd[ACCW-2:0], 1'b1};
    end
    q_neg    = acc[ACCW-1] ^ num_q[DATAWIDTH-1];
    q_signed = $signed({1'b0, quo});
    if (q_neg) q_signed = -q_signed;
    q_sat    = sat_fn(q_signed);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (clamp_cnt(num_samples) == '0) ? DIVIDE : ACCUM;
      ACCUM:  if (xfer && cnt_left == CNTW'(1)) state_nxt = DIVIDE;
      DIVIDE: if (num_q == '0 || iter == ITW'(ACCW)) state_nxt = DONE;
      DONE:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latching, accumulation, division iterations and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_left <= '0;
      num_q    <= '0;
      acc      <= '0;
      quo      <= '0;
      rem      <= '0;
      iter     <= '0;
      avg_q    <= '0;
      sat_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_q    <= num;
            cnt_left <= clamp_cnt(num_samples);
            acc      <= '0;
            quo      <= '0;
            rem      <= '0;
            iter     <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc      <= acc + {{CNTW{in_data[DATAWIDTH-1]}}, in_data};
            cnt_left <= cnt_left - CNTW'(1);
          end
        end
        DIVIDE: begin
          if (num_q == '0) begin
            avg_q <= '0;
            sat_q <= 1'b0;
            dz_q  <= 1'b1;
          end else if (iter != ITW'(ACCW)) begin
            rem  <= rem_nx;
            quo  <= quo_nx;
            iter <= iter + ITW'(1);
          end else begin
            avg_q <= q_sat[DATAWIDTH-1:0];
            sat_q <= q_sat[DATAWIDTH];
            dz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_avg_div.sv
// Scoreboard bench for stream_avg_div: directed operations push expected
// results into a queue, a monitor pops and compares on each output accept.
module tb_stream_avg_div;

  logic               clk;
  logic               rst;
  logic               start;
  logic [3:0]         num_samples;
  logic signed [15:0] num;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] avg;
  logic               sat;
  logic               div_zero;

  typedef struct packed {
    logic signed [15:0] avg;
    logic               sat;
    logic               dz;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  stream_avg_div dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .num(num),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .avg(avg), .sat(sat),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic exp_push(input int a, input int s, input int z);
    exp_t e;
    e.avg = 16'(a);
    e.sat = 1'(s);
    e.dz  = 1'(z);
    expq.push_back(e);
  endtask

  task automatic start_op(input logic [3:0] ns, input logic signed [15:0] dv);
    start = 1'b1; num_samples = ns; num = dv;
    @(posedge clk); #1;
    start = 1'b0;
    num_samples = 4'($urandom_range(15, 0));
    num = 16'($urandom_range(65535, 0));
  endtask

  // Gap cycles carry a start pulse that must be ignored while accumulating.
  task automatic push_sample(input logic signed [15:0] d, input int gap);
    int g;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0; start = 1'b1; num_samples = 4'd1; num = 16'sd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b1; in_data = d;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    chk("out_valid_after_accept", out_valid, 0);
  endtask

  // Monitor: compares each accepted result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = expq.pop_front();
          chk("avg", avg, e.avg);
          chk("sat", sat, e.sat);
          chk("div_zero", div_zero, e.dz);
        end
      end
    end
  end

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; start = 1'b0; num_samples = '0; num = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_avg", avg, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1..8 / 8 = 4, with latency check
    exp_push(4, 0, 0);
    start_op(4'd8, 16'sd8);
    for (int i = 1; i <= 8; i++) push_sample(16'(i), 0);
    wait_result(lat);
    chk("latency_avg", lat, 21);
    finish_op();

    // -81 / 8 truncates to -10; -81 / -8 gives 10
    exp_push(-10, 0, 0);
    start_op(4'd8, 16'sd8);
    for (int i = 0; i < 7; i++) push_sample(-16'sd10, 0);
    push_sample(-16'sd11, 0);
    wait_result(lat);
    finish_op();
    exp_push(10, 0, 0);
    start_op(4'd8, -16'sd8);
    for (int i = 0; i < 7; i++) push_sample(-16'sd10, 0);
    push_sample(-16'sd11, 0);
    wait_result(lat);
    finish_op();

    // saturation both directions
    exp_push(32767, 1, 0);
    start_op(4'd8, 16'sd1);
    for (int i = 0; i < 8; i++) push_sample(16'sd32767, 0);
    wait_result(lat);
    finish_op();
    exp_push(-32768, 1, 0);
    start_op(4'd8, -16'sd1);
    for (int i = 0; i < 8; i++) push_sample(16'sd32767, 0);
    wait_result(lat);
    finish_op();

    // count of 15 clamps to 8: 262136 / 8 = 32767 exactly, no saturation
    exp_push(32767, 0, 0);
    start_op(4'd15, 16'sd8);
    for (int i = 0; i < 8; i++) push_sample(16'sd32767, 0);
    chk("clamp_in_ready_low", in_ready, 0);
    wait_result(lat);
    chk("latency_clamp", lat, 21);
    finish_op();

    // divide by zero: result one edge after last accept
    exp_push(0, 0, 1);
    start_op(4'd3, 16'sd0);
    push_sample(16'sd1, 0);
    push_sample(16'sd2, 0);
    push_sample(16'sd3, 0);
    wait_result(lat);
    chk("latency_div_zero", lat, 1);
    finish_op();

    // empty run: never ready, zero result
    exp_push(0, 0, 0);
    start_op(4'd0, 16'sd5);
    seen = 1'b0; lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    chk("empty_in_ready_seen", seen, 0);
    chk("latency_empty", lat, 21);
    finish_op();

    // gaps, ignored starts, held output: (5 - 7 + 20) / 3 = 6
    out_ready = 1'b0;
    exp_push(6, 0, 0);
    start_op(4'd3, 16'sd3);
    push_sample(16'sd5, 2);
    push_sample(-16'sd7, 0);
    push_sample(16'sd20, 3);
    start = 1'b1; num_samples = 4'd1; num = 16'sd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_result(lat);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_avg", avg, 6);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("accept_out_valid", out_valid, 0);
    chk("accept_start_ignored", in_ready, 0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);

    // asynchronous reset mid-accumulation
    start_op(4'd8, 16'sd8);
    for (int i = 0; i < 4; i++) push_sample(16'sd100, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_avg", avg, 0);
    chk("async_rst_sat", sat, 0);
    chk("async_rst_dz", div_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_push(2, 0, 0);
    start_op(4'd2, 16'sd2);
    push_sample(16'sd2, 0);
    push_sample(16'sd2, 0);
    wait_result(lat);
    finish_op();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
